// File: rtl/daub6_dwt_stream_if.sv
// rtl/daub6_dwt_stream_if.sv - sample-in / pair-out stream bundle for the db3 analysis stage
interface daub6_dwt_stream_if #(
  parameter int DATA_WIDTH = 16
);
  logic signed [DATA_WIDTH-1:0] in;
  logic                         in_valid;
  logic                         in_last;
  logic                         in_ready;
  logic signed [DATA_WIDTH-1:0] out_approx;
  logic signed [DATA_WIDTH-1:0] out_detail;
  logic                         out_valid;
  logic                         out_last;
  logic                         out_ready;

  modport master (
    output in, in_valid, in_last, out_ready,
    input  in_ready, out_approx, out_detail, out_valid, out_last
  );

  modport slave (
    input  in, in_valid, in_last, out_ready,
    output in_ready, out_approx, out_detail, out_valid, out_last
  );
endinterface

// File: rtl/daub6_dwt_stream.sv
// rtl/daub6_dwt_stream.sv - one-level db3 forward DWT, streaming, with framing, pad and tail flush
module daub6_dwt_stream #(
  parameter int DATA_WIDTH = 16,
  parameter int COEF_WIDTH = 16,
  parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + 3,
  parameter int SATURATE   = 1
) (
  input logic               clk,
  input logic               rst,
  daub6_dwt_stream_if.slave s
);
  localparam int PW = DATA_WIDTH + COEF_WIDTH;
  localparam logic signed [ACC_WIDTH-1:0]  RND     = ACC_WIDTH'(1) << (COEF_WIDTH - 2);
  localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0]  SAT_MAX = ACC_WIDTH'(OUT_MAX);
  localparam logic signed [ACC_WIDTH-1:0]  SAT_MIN = ACC_WIDTH'(OUT_MIN);

  typedef enum logic [1:0] {RUN, PAD, FLUSH} state_t;

  function automatic logic signed [COEF_WIDTH-1:0] h_coef(input int k);
    logic signed [COEF_WIDTH-1:0] c;
    case (k)
      0:       c = COEF_WIDTH'(10901);
      1:       c = COEF_WIDTH'(26440);
      2:       c = COEF_WIDTH'(15069);
      3:       c = COEF_WIDTH'(-4424);
      4:       c = COEF_WIDTH'(-2800);
      5:       c = COEF_WIDTH'(1154);
      default: c = '0;
    endcase
    return c <<< (COEF_WIDTH - 16);
  endfunction

  function automatic logic signed [COEF_WIDTH-1:0] g_coef(input int k);
    return (k % 2 == 1) ? -h_coef(5 - k) : h_coef(5 - k);
  endfunction

  // Round half up, then clamp or wrap into the output width.
  function automatic logic signed [DATA_WIDTH-1:0] narrow(input logic signed [ACC_WIDTH-1:0] a);
    logic signed [ACC_WIDTH-1:0] r;
    r = (a + RND) >>> (COEF_WIDTH - 1);
    if (SATURATE != 0 && r > SAT_MAX) return OUT_MAX;
    if (SATURATE != 0 && r < SAT_MIN) return OUT_MIN;
    return r[DATA_WIDTH-1:0];
  endfunction

  state_t                       state, state_n;
  logic signed [DATA_WIDTH-1:0] x      [6];
  logic signed [DATA_WIDTH-1:0] x_next [6];
  logic                         phase;
  logic [1:0]                   tail, tail_n;
  logic                         stall, accept;
  logic                         shift_en, load, load_last, clear;
  logic signed [DATA_WIDTH-1:0] shift_in;
  logic signed [ACC_WIDTH-1:0]  acc_a, acc_d;
  logic signed [DATA_WIDTH-1:0] approx_q, detail_q;
  logic                         valid_q, last_q;

  assign stall      = valid_q && !s.out_ready;
  assign s.in_ready = rst && (state == RUN) && !stall;
  assign accept     = s.in_valid && s.in_ready;

  assign s.out_approx = approx_q;
  assign s.out_detail = detail_q;
  assign s.out_valid  = valid_q;
  assign s.out_last   = last_q;

  always_comb begin
    state_n   = state;
    tail_n    = tail;
    shift_en  = 1'b0;
    shift_in  = s.in;
    load      = 1'b0;
    load_last = 1'b0;
    clear     = 1'b0;
    case (state)
      RUN: begin
        if (accept) begin
          shift_en = 1'b1;
          load     = phase;
          if (s.in_last) state_n = phase ? FLUSH : PAD;
        end
      end
      PAD: begin
        if (!stall) begin
          shift_en = 1'b1;
          shift_in = '0;
          load     = 1'b1;
          state_n  = FLUSH;
        end
      end
      FLUSH: begin
        // After two tail pairs, wait for the final pair to leave before rearming.
        if (tail == 2'd2) begin
          if (valid_q && s.out_ready) begin
            clear   = 1'b1;
            tail_n  = 2'd0;
            state_n = RUN;
          end
        end else if (!stall) begin
          shift_en = 1'b1;
          shift_in = '0;
          if (phase) begin
            load      = 1'b1;
            load_last = (tail == 2'd1);
            tail_n    = tail + 2'd1;
          end
        end
      end
      default: state_n = RUN;
    endcase
  end

  always_comb begin
    x_next[0] = shift_in;
    for (int k = 1; k < 6; k++) x_next[k] = x[k-1];
  end

  always_comb begin
    logic signed [PW-1:0] pa;
    logic signed [PW-1:0] pd;
    acc_a = '0;
    acc_d = '0;
    pa    = '0;
    pd    = '0;
    for (int k = 0; k < 6; k++) begin
      pa    = PW'(x_next[k]) * PW'(h_coef(k));
      pd    = PW'(x_next[k]) * PW'(g_coef(k));
      acc_a = acc_a + ACC_WIDTH'(pa);
      acc_d = acc_d + ACC_WIDTH'(pd);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= RUN;
      tail     <= 2'd0;
      phase    <= 1'b0;
      for (int k = 0; k < 6; k++) x[k] <= '0;
      approx_q <= '0;
      detail_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state <= state_n;
      tail  <= tail_n;
      if (clear) begin
        for (int k = 0; k < 6; k++) x[k] <= '0;
        phase <= 1'b0;
      end else if (shift_en) begin
        for (int k = 0; k < 6; k++) x[k] <= x_next[k];
        phase <= !phase;
      end
      if (load) begin
        approx_q <= narrow(acc_a);
        detail_q <= narrow(acc_d);
        valid_q  <= 1'b1;
        last_q   <= load_last;
      end else if (valid_q && s.out_ready) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end
endmodule
